// File: rtl/fsm_mon_pkg.sv
// Shared types and constants for the FSM sequence monitor.
// Holds the monitor state enum and the encoding of the reported fault cause.
package fsm_mon_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2,
        S_LOCK  = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_JUMP    = 2'b10;
    localparam logic [1:0] CAUSE_STALL   = 2'b11;

endpackage

// File: rtl/fsm_sequence_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// The clear input has priority over the increment input.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: reset or clear to zero, otherwise increment until all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/fsm_sequence_monitor.sv
// Checker that follows an upstream FSM's state code through the cycle 0->1->..->N-1->0,
// reporting illegal codes, skipped states and stalls, and locking after repeated faults.
module fsm_sequence_monitor
    import fsm_mon_pkg::*;
#(
    parameter int CODE_W      = 3,
    parameter int NUM_STATES  = 4,
    parameter int STALL_MAX   = 16,
    parameter int CNT_W       = 8,
    parameter int FAULT_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    input  logic              clear_req,
    output logic              alarm,
    output logic              lock,
    output logic [1:0]        fault_cause,
    output logic              in_sync,
    output logic [CODE_W-1:0] last_code,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int STALL_W = $clog2(STALL_MAX + 1);
    localparam int FAULT_W = $clog2(FAULT_LIMIT + 1);
    localparam logic [CODE_W-1:0]  CODE_LAST  = CODE_W'(NUM_STATES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
    localparam logic [FAULT_W-1:0] FAULT_LAST = FAULT_W'(FAULT_LIMIT - 1);

    state_e              state_r, state_nx_s;
    logic                alarm_r, alarm_nx_s;
    logic                lock_r, lock_nx_s;
    logic [1:0]          cause_r, cause_nx_s;
    logic                in_sync_r, in_sync_nx_s;
    logic [CODE_W-1:0]   last_code_r, last_code_nx_s;

    logic                fault_s;
    logic [1:0]          fault_kind_s;
    logic                cyc_inc_s, stall_inc_s, stall_clr_s;
    logic [CODE_W-1:0]   succ_s;
    logic [STALL_W-1:0]  stall_cnt_s;
    logic [FAULT_W-1:0]  fault_cnt_s;
    logic [CNT_W-1:0]    cycle_cnt_s;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            alarm_r     <= 1'b0;
            lock_r      <= 1'b0;
            cause_r     <= CAUSE_NONE;
            in_sync_r   <= 1'b0;
            last_code_r <= {CODE_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            alarm_r     <= alarm_nx_s;
            lock_r      <= lock_nx_s;
            cause_r     <= cause_nx_s;
            in_sync_r   <= in_sync_nx_s;
            last_code_r <= last_code_nx_s;
        end
    end

    // Next-state, fault detection and counter control.
    always_comb begin
        state_nx_s     = state_r;
        alarm_nx_s     = alarm_r;
        lock_nx_s      = lock_r;
        cause_nx_s     = cause_r;
        in_sync_nx_s   = in_sync_r;
        last_code_nx_s = last_code_r;
        fault_s        = 1'b0;
        fault_kind_s   = CAUSE_NONE;
        cyc_inc_s      = 1'b0;
        stall_inc_s    = 1'b0;
        stall_clr_s    = 1'b0;
        if (last_code_r == CODE_LAST) begin
            succ_s = {CODE_W{1'b0}};
        end else begin
            succ_s = last_code_r + {{(CODE_W-1){1'b0}}, 1'b1};
        end

        case (state_r)
            S_IDLE: begin
                if (!code_valid) begin
                    state_nx_s = S_IDLE;
                end else if (code_in > CODE_LAST) begin
                    fault_s      = 1'b1;
                    fault_kind_s = CAUSE_ILLEGAL;
                end else if (code_in == {CODE_W{1'b0}}) begin
                    state_nx_s     = S_TRACK;
                    in_sync_nx_s   = 1'b1;
                    last_code_nx_s = {CODE_W{1'b0}};
                    stall_clr_s    = 1'b1;
                end else begin
                    fault_s      = 1'b1;
                    fault_kind_s = CAUSE_JUMP;
                end
            end
            S_TRACK: begin
                if (!code_valid) begin
                    state_nx_s = S_TRACK;
                end else if (code_in > CODE_LAST) begin
                    fault_s      = 1'b1;
                    fault_kind_s = CAUSE_ILLEGAL;
                end else if (code_in == succ_s) begin
                    last_code_nx_s = code_in;
                    stall_clr_s    = 1'b1;
                    cyc_inc_s      = (last_code_r == CODE_LAST);
                end else if (code_in == last_code_r) begin
                    if (stall_cnt_s == STALL_LAST) begin
                        fault_s      = 1'b1;
                        fault_kind_s = CAUSE_STALL;
                    end else begin
                        stall_inc_s = 1'b1;
                    end
                end else begin
                    fault_s      = 1'b1;
                    fault_kind_s = CAUSE_JUMP;
                end
            end
            S_FAULT: begin
                // The clear takes effect regardless of any code presented alongside it.
                if (clear_req) begin
                    state_nx_s  = S_IDLE;
                    alarm_nx_s  = 1'b0;
                    cause_nx_s  = CAUSE_NONE;
                    stall_clr_s = 1'b1;
                end else begin
                    state_nx_s = S_FAULT;
                end
            end
            S_LOCK: begin
                state_nx_s = S_LOCK;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase

        if (fault_s) begin
            cause_nx_s   = fault_kind_s;
            alarm_nx_s   = 1'b1;
            in_sync_nx_s = 1'b0;
            if (fault_cnt_s == FAULT_LAST) begin
                state_nx_s = S_LOCK;
                lock_nx_s  = 1'b1;
            end else begin
                state_nx_s = S_FAULT;
            end
        end else begin
            cause_nx_s = cause_nx_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (cyc_inc_s),
        .count (cycle_cnt_s)
    );

    sat_counter #(.W(STALL_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (stall_clr_s),
        .inc   (stall_inc_s),
        .count (stall_cnt_s)
    );

    sat_counter #(.W(FAULT_W)) u_fault_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (fault_s),
        .count (fault_cnt_s)
    );

    assign alarm       = alarm_r;
    assign lock        = lock_r;
    assign fault_cause = cause_r;
    assign in_sync     = in_sync_r;
    assign last_code   = last_code_r;
    assign cycle_count = cycle_cnt_s;

endmodule

// File: tb/tb_fsm_sequence_monitor.sv
// Self-checking bench for fsm_sequence_monitor: directed scenarios plus random traffic,
// all compared against a rule-level reference model.
module tb_fsm_sequence_monitor;

    logic       clk;
    logic       rst;
    logic [2:0] code_in;
    logic       code_valid;
    logic       clear_req;
    logic       alarm;
    logic       lock;
    logic [1:0] fault_cause;
    logic       in_sync;
    logic [2:0] last_code;
    logic [7:0] cycle_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: rule-level view of the monitor.
    bit m_tracking, m_faulted, m_locked;
    int m_last, m_rot, m_rep, m_nfault, m_cause;

    fsm_sequence_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .clear_req   (clear_req),
        .alarm       (alarm),
        .lock        (lock),
        .fault_cause (fault_cause),
        .in_sync     (in_sync),
        .last_code   (last_code),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tracking = 1'b0; m_faulted = 1'b0; m_locked = 1'b0;
        m_last = 0; m_rot = 0; m_rep = 0; m_nfault = 0; m_cause = 0;
    endtask

    task automatic model_step(input bit v, input int c, input bit cl);
        int cause;
        cause = 0;
        if (m_locked) begin
            cause = 0;
        end else if (m_faulted) begin
            if (cl) begin
                m_faulted = 1'b0; m_cause = 0; m_rep = 0;
            end
        end else if (v) begin
            if (c >= 4) cause = 1;
            else if (!m_tracking) begin
                if (c == 0) begin m_tracking = 1'b1; m_last = 0; m_rep = 0; end
                else cause = 2;
            end else if (c == (m_last + 1) % 4) begin
                if (c == 0) m_rot = (m_rot < 255) ? m_rot + 1 : 255;
                m_last = c; m_rep = 0;
            end else if (c == m_last) begin
                m_rep++;
                if (m_rep == 16) cause = 3;
            end else cause = 2;
            if (cause != 0) begin
                m_nfault++;
                m_cause = cause;
                m_tracking = 1'b0;
                if (m_nfault >= 3) m_locked = 1'b1;
                else m_faulted = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".alarm"},   int'(alarm),       int'(m_faulted || m_locked));
        chk({tag, ".lock"},    int'(lock),        int'(m_locked));
        chk({tag, ".cause"},   int'(fault_cause), m_cause);
        chk({tag, ".in_sync"}, int'(in_sync),     int'(m_tracking));
        chk({tag, ".last"},    int'(last_code),   m_last);
        chk({tag, ".cycles"},  int'(cycle_count), m_rot);
    endtask

    task automatic step(input string tag, input bit v, input int c, input bit cl);
        code_valid = v; code_in = 3'(c); clear_req = cl;
        @(posedge clk);
        model_step(v, c, cl);
        #1;
        check_all(tag);
        code_valid = 1'b0; clear_req = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; code_valid = 1'b0; clear_req = 1'b0; code_in = 3'd0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; code_in = 3'd0; code_valid = 1'b0; clear_req = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_reset("reset");
        chk("reset.alarm_const", int'(alarm), 0);

        // 1: legal rotation
        step("t1", 1'b1, 0, 1'b0); step("t1", 1'b1, 1, 1'b0);
        step("t1", 1'b1, 2, 1'b0); step("t1", 1'b1, 3, 1'b0);
        step("t1", 1'b1, 0, 1'b0);
        chk("t1.cycle_after_wrap", int'(cycle_count), 1);
        step("t1", 1'b1, 1, 1'b0);
        chk("t1.last_end", int'(last_code), 1);
        chk("t1.in_sync_end", int'(in_sync), 1);

        // 2: illegal code, clear, resume
        do_reset("t2.rst");
        step("t2", 1'b1, 0, 1'b0); step("t2", 1'b1, 1, 1'b0);
        step("t2.ill", 1'b1, 5, 1'b0);
        chk("t2.cause_ill", int'(fault_cause), 1);
        chk("t2.last_kept", int'(last_code), 1);
        step("t2.clr", 1'b0, 0, 1'b1);
        chk("t2.alarm_clr", int'(alarm), 0);
        step("t2.resume", 1'b1, 0, 1'b0);
        chk("t2.resync", int'(in_sync), 1);

        // 3: jumps, idle entry, valid gaps
        do_reset("t3.rst");
        step("t3", 1'b1, 0, 1'b0); step("t3", 1'b0, 2, 1'b0);
        step("t3", 1'b1, 1, 1'b0); step("t3", 1'b0, 3, 1'b0);
        step("t3.jump", 1'b1, 3, 1'b0);
        chk("t3.cause_jump", int'(fault_cause), 2);
        step("t3.clr", 1'b0, 0, 1'b1);
        step("t3.idle2", 1'b1, 2, 1'b0);
        chk("t3.cause_idle", int'(fault_cause), 2);

        // 4: stall boundary
        do_reset("t4.rst");
        step("t4", 1'b1, 0, 1'b0); step("t4", 1'b1, 1, 1'b0); step("t4", 1'b1, 2, 1'b0);
        for (int i = 0; i < 15; i++) step("t4.rep15", 1'b1, 2, 1'b0);
        step("t4.to3", 1'b1, 3, 1'b0);
        chk("t4.no_fault15", int'(alarm), 0);
        step("t4", 1'b1, 0, 1'b0); step("t4", 1'b1, 1, 1'b0); step("t4", 1'b1, 2, 1'b0);
        for (int i = 0; i < 16; i++) step("t4.rep16", 1'b1, 2, 1'b0);
        chk("t4.cause_stall", int'(fault_cause), 3);

        // 5: lock escalation and same-cycle clear
        do_reset("t5.rst");
        step("t5", 1'b1, 0, 1'b0); step("t5", 1'b1, 1, 1'b0); step("t5.f1", 1'b1, 3, 1'b0);
        step("t5.clr1", 1'b0, 0, 1'b1);
        step("t5.f2", 1'b1, 5, 1'b0);
        step("t5.clr2", 1'b0, 0, 1'b1);
        step("t5.f3", 1'b1, 2, 1'b0);
        chk("t5.locked", int'(lock), 1);
        step("t5.ign_clr", 1'b0, 0, 1'b1);
        step("t5.ign_code", 1'b1, 0, 1'b0);
        chk("t5.still_lock", int'(lock), 1);
        chk("t5.final_cause", int'(fault_cause), 2);
        do_reset("t5.unlock");
        chk("t5.unlock_lock", int'(lock), 0);
        step("t5.f", 1'b1, 7, 1'b0);
        step("t5.clr_and_7", 1'b1, 7, 1'b1);
        chk("t5.clr_wins", int'(alarm), 0);

        // 6: reset mid-operation
        do_reset("t6.rst");
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 4; k++) step("t6.rot", 1'b1, k, 1'b0);
        step("t6.rot", 1'b1, 0, 1'b0);
        chk("t6.five", int'(cycle_count), 5);
        do_reset("t6.mid");
        for (int f = 0; f < 3; f++) begin
            step("t6.f", 1'b1, 6, 1'b0);
            chk("t6.lock_progress", int'(lock), (f == 2) ? 1 : 0);
            step("t6.clr", 1'b0, 0, 1'b1);
        end

        // Random traffic
        do_reset("rnd.rst");
        for (int n = 0; n < 3000; n++) begin
            int c, sel;
            bit v, cl;
            if (m_locked && ($urandom_range(0, 7) == 0)) begin
                do_reset("rnd.rst");
            end else begin
                sel = int'($urandom_range(0, 99));
                if (sel < 60)      c = (m_last + 1) % 4;
                else if (sel < 80) c = m_last;
                else if (sel < 85) c = 0;
                else               c = int'($urandom_range(0, 7));
                v  = ($urandom_range(0, 9) != 0);
                cl = ($urandom_range(0, 9) == 0);
                step("rnd", v, c, cl);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
